// File: rtl/baud_pkg.sv
// Shared types and constants for the baud tick controller.
package baud_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } baud_state_e;

    localparam int MIN_DIV          = 2;
    localparam int BAUD_DEFAULT_OVS = 16;
    // 50 MHz / (16 x 115200)
    localparam int BAUD_DEFAULT_DIV = 27;

endpackage

// File: rtl/baud_ctrl_if.sv
// Control/status bundle between the baud controller and its user.
interface baud_ctrl_if #(
    parameter int N = 16
);
    logic         en;
    logic         resync;
    logic         cfg_valid;
    logic [N-1:0] cfg_div;
    logic         cfg_ready;
    logic         cfg_err;
    logic [N-1:0] div_q;
    logic         tick;
    logic         bit_tick;
    logic [N-1:0] q;

    modport master (
        output en, resync, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, div_q, tick, bit_tick, q
    );

    modport slave (
        input  en, resync, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, div_q, tick, bit_tick, q
    );
endinterface

// File: rtl/baud_div_cnt.sv
// Loadable mod-div counter with synchronous clear; wrap flags the last count.
module baud_div_cnt #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         cnt_en,
    input  logic [N-1:0] div,
    output logic [N-1:0] q,
    output logic         wrap
);

    logic [N-1:0] q_d;
    logic [N-1:0] q_q;

    assign wrap = (q_q == (div - N'(1)));
    assign q    = q_q;

    // Next count: clear dominates, then wrap-or-increment while enabled.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (cnt_en) begin
            q_d = wrap ? '0 : (q_q + N'(1));
        end else begin
            q_d = q_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/baud_ctrl.sv
// Programmable baud tick controller: divisor FSM, config handshake, oversample count.
// Optional feature macro: BAUD_CTRL_BIT_TICK_EN (enables ovs_cnt and bit_tick).
module baud_ctrl
    import baud_pkg::*;
#(
    parameter int N           = 16,
    parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV,
    parameter int OVS         = BAUD_DEFAULT_OVS
) (
    input logic       clk,
    input logic       reset,
    baud_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_PEND = ST_PEND;

    if (DEFAULT_DIV < MIN_DIV || OVS < 2 || (OVS & (OVS - 1)) != 0) begin : g_bad_cfg
        $error("baud_ctrl: DEFAULT_DIV must be >= 2 and OVS a power of two >= 2");
    end

    logic [1:0]   state_q, state_d;
    logic [N-1:0] div_cur_q, div_cur_d;
    logic [N-1:0] stage_q, stage_d;
    logic         err_q, err_d;

    logic         xfer_s;
    logic         cfg_bad_s;
    logic         cfg_good_s;
    logic         cnt_clr_s;
    logic         cnt_en_s;
    logic         wrap_s;
    logic         tick_s;
    logic [N-1:0] q_s;

    assign bus.cfg_ready = (state_q != S_PEND);
    assign xfer_s        = bus.cfg_valid && bus.cfg_ready;
    assign cfg_bad_s     = xfer_s && (bus.cfg_div < N'(MIN_DIV));
    assign cfg_good_s    = xfer_s && !cfg_bad_s;
    assign cnt_en_s      = (state_q != S_IDLE);
    assign tick_s        = cnt_en_s && wrap_s && !bus.resync;

    assign bus.tick    = tick_s;
    assign bus.q       = q_s;
    assign bus.div_q   = div_cur_q;
    assign bus.cfg_err = err_q;

    baud_div_cnt #(.N(N)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr_s),
        .cnt_en (cnt_en_s),
        .div    (div_cur_q),
        .q      (q_s),
        .wrap   (wrap_s)
    );

    // FSM, divisor apply/stage and counter-clear decisions.
    always_comb begin
        state_d   = state_q;
        div_cur_d = div_cur_q;
        stage_d   = stage_q;
        cnt_clr_s = 1'b0;
        if (cfg_bad_s) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                cnt_clr_s = 1'b1;
                if (cfg_good_s) begin
                    div_cur_d = bus.cfg_div;
                end else begin
                    div_cur_d = div_cur_q;
                end
                if (bus.en) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!bus.en) begin
                    // A write landing together with en=0 takes effect on entry to IDLE.
                    state_d   = S_IDLE;
                    cnt_clr_s = 1'b1;
                    if (cfg_good_s) begin
                        div_cur_d = bus.cfg_div;
                    end else begin
                        div_cur_d = div_cur_q;
                    end
                end else begin
                    if (cfg_good_s) begin
                        stage_d = bus.cfg_div;
                        state_d = S_PEND;
                    end else begin
                        state_d = S_RUN;
                    end
                    cnt_clr_s = bus.resync;
                end
            end
            S_PEND: begin
                if (!bus.en || bus.resync || tick_s) begin
                    div_cur_d = stage_q;
                    stage_d   = '0;
                    cnt_clr_s = 1'b1;
                    state_d   = bus.en ? S_RUN : S_IDLE;
                end else begin
                    state_d = S_PEND;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_cur_q <= N'(DEFAULT_DIV);
            stage_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cur_q <= div_cur_d;
            stage_q   <= stage_d;
            err_q     <= err_d;
        end
    end

`ifdef BAUD_CTRL_BIT_TICK_EN
    localparam int OW = $clog2(OVS);
    localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);

    logic [OW-1:0] ovs_cnt_q, ovs_cnt_d;

    assign bus.bit_tick = tick_s && (ovs_cnt_q == OVS_LAST);

    // Oversample count restarts whenever the divisor counter is cleared.
    always_comb begin
        ovs_cnt_d = ovs_cnt_q;
        if (cnt_clr_s) begin
            ovs_cnt_d = '0;
        end else if (tick_s) begin
            ovs_cnt_d = ovs_cnt_q + OW'(1);
        end else begin
            ovs_cnt_d = ovs_cnt_q;
        end
    end

    // Oversample counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovs_cnt_q <= '0;
        end else begin
            ovs_cnt_q <= ovs_cnt_d;
        end
    end
`else
    assign bus.bit_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed bench for baud_ctrl: tick-edge scoreboard plus register/handshake checks.
module tb_baud_ctrl;

    localparam int N = 16;
`ifdef BAUD_CTRL_BIT_TICK_EN
    localparam bit BT = 1'b1;
`else
    localparam bit BT = 1'b0;
`endif

    typedef struct {
        int   edge_n;
        logic bit_v;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    baud_ctrl_if #(.N(N)) bus ();

    baud_ctrl #(.N(N), .DEFAULT_DIV(27), .OVS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected tick k (1..n) ends at edge base + k*div; every 16th carries bit_tick.
    task automatic sched(input int base, input int div, input int n);
        for (int k = 1; k <= n; k++) begin
            exp_q.push_back('{edge_n: base + k * div, bit_v: BT && ((k % 16) == 0)});
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_q"}, 32'(bus.q), 32'd0);
        chk({tag, "_div_q"}, 32'(bus.div_q), 32'd27);
        chk({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
        chk({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'd0);
        chk({tag, "_tick"}, 32'(bus.tick), 32'd0);
        chk({tag, "_bit_tick"}, 32'(bus.bit_tick), 32'd0);
    endtask

    task automatic cfg_write(input logic [N-1:0] d);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = d;
        step(1);
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int e;
        int r1;
        bus.en        = 1'b0;
        bus.resync    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;

        // Tick monitor: pop the oldest expectation on every observed tick.
        fork
            forever begin
                @(negedge clk);
                if (cyc > 0) begin
                    chk("bit_tick_without_tick",
                        32'(bus.bit_tick === 1'b1 && bus.tick !== 1'b1), 32'd0);
                    if (bus.tick === 1'b1) begin
                        n_cmp++;
                        assert (exp_q.size() != 0) else begin
                            n_bad++;
                            $error("FAIL unexpected_tick: observed tick ending edge %0d expected none",
                                   cyc + 1);
                        end
                        if (exp_q.size() != 0) begin
                            exp_t x;
                            x = exp_q.pop_front();
                            chk("tick_edge", 32'(cyc + 1), 32'(x.edge_n));
                            chk("bit_tick", 32'(bus.bit_tick), 32'(x.bit_v));
                        end
                    end
                end
            end
        join_none

        // Reset values, held over several cycles.
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_reset_vals("reset");
        end

        // Default rate 27: 17 ticks, bit_tick on the 16th (432 cycles).
        reset  = 1'b0;
        bus.en = 1'b1;
        e = cyc + 1;
        sched(e, 27, 17);
        step(462);
        bus.en = 1'b0;
        step(2);
        chk("drain_default", 32'(exp_q.size()), 32'd0);

        // IDLE write of 10 takes effect next edge, then tick every 10.
        chk("idle_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        cfg_write(16'd10);
        chk("idle_div_q_10", 32'(bus.div_q), 32'd10);
        chk("idle_no_err", 32'(bus.cfg_err), 32'd0);
        bus.en = 1'b1;
        e = cyc + 1;
        sched(e, 10, 5);
        step(53);
        bus.en = 1'b0;
        step(2);
        chk("drain_div10", 32'(exp_q.size()), 32'd0);

        // Running at 27, write 5 at q=8: old tick kept, then every 5.
        cfg_write(16'd27);
        bus.en = 1'b1;
        e = cyc + 1;
        step(9);
        chk("run_q_8", 32'(bus.q), 32'd8);
        chk("run_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        exp_q.push_back('{edge_n: e + 27, bit_v: 1'b0});
        sched(e + 27, 5, 4);
        cfg_write(16'd5);
        chk("pend_cfg_ready_low", 32'(bus.cfg_ready), 32'd0);
        chk("pend_div_q_old", 32'(bus.div_q), 32'd27);
        step(18);
        chk("apply_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("apply_div_q_5", 32'(bus.div_q), 32'd5);
        chk("apply_q_0", 32'(bus.q), 32'd0);
        step(21);
        bus.en = 1'b0;
        step(2);
        chk("drain_change", 32'(exp_q.size()), 32'd0);

        // Invalid divisors 1 then 0: one error pulse each, divisor kept.
        cfg_write(16'd1);
        chk("err1_pulse", 32'(bus.cfg_err), 32'd1);
        chk("err1_div_q", 32'(bus.div_q), 32'd5);
        step(1);
        chk("err1_cleared", 32'(bus.cfg_err), 32'd0);
        cfg_write(16'd0);
        chk("err0_pulse", 32'(bus.cfg_err), 32'd1);
        step(1);
        chk("err0_cleared", 32'(bus.cfg_err), 32'd0);
        chk("err0_div_q", 32'(bus.div_q), 32'd5);
        chk("err0_cfg_ready", 32'(bus.cfg_ready), 32'd1);

        // Resync at q=20, then at q=26 (tick suppressed), then while PEND.
        cfg_write(16'd27);
        bus.en = 1'b1;
        e = cyc + 1;
        step(21);
        chk("resync_q_20", 32'(bus.q), 32'd20);
        bus.resync = 1'b1;
        r1 = cyc + 1;
        step(1);
        bus.resync = 1'b0;
        chk("resync_q_0", 32'(bus.q), 32'd0);
        exp_q.push_back('{edge_n: r1 + 27, bit_v: 1'b0});
        step(53);
        chk("resync_q_26", 32'(bus.q), 32'd26);
        bus.resync = 1'b1;
        step(1);
        bus.resync = 1'b0;
        step(3);
        cfg_write(16'd7);
        step(2);
        chk("pend_resync_q_6", 32'(bus.q), 32'd6);
        bus.resync = 1'b1;
        step(1);
        bus.resync = 1'b0;
        chk("pend_resync_div_q", 32'(bus.div_q), 32'd7);
        chk("pend_resync_q_0", 32'(bus.q), 32'd0);
        chk("pend_resync_ready", 32'(bus.cfg_ready), 32'd1);
        sched(r1 + 61, 7, 3);
        step(22);
        bus.en = 1'b0;
        step(2);
        chk("drain_resync", 32'(exp_q.size()), 32'd0);

        // en=0 while PEND with 12 staged: IDLE, divisor applied, no ticks.
        bus.en = 1'b1;
        step(3);
        cfg_write(16'd12);
        bus.en = 1'b0;
        step(1);
        chk("pend_off_div_q", 32'(bus.div_q), 32'd12);
        chk("pend_off_q", 32'(bus.q), 32'd0);
        chk("pend_off_ready", 32'(bus.cfg_ready), 32'd1);
        step(10);
        chk("idle_q_held", 32'(bus.q), 32'd0);

        // en=0 together with a write in RUN: applied on entry to IDLE.
        bus.en = 1'b1;
        step(3);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 16'd9;
        bus.en        = 1'b0;
        step(1);
        bus.cfg_valid = 1'b0;
        chk("off_xfer_div_q", 32'(bus.div_q), 32'd9);
        chk("off_xfer_q", 32'(bus.q), 32'd0);
        chk("drain_idle", 32'(exp_q.size()), 32'd0);

        // Reset mid-run returns everything to reset values.
        bus.en = 1'b1;
        e = cyc + 1;
        sched(e, 9, 1);
        step(12);
        chk("midrun_q_2", 32'(bus.q), 32'd2);
        reset = 1'b1;
        step(1);
        chk_reset_vals("midrun_reset");
        bus.en = 1'b0;
        reset  = 1'b0;
        step(2);
        chk("drain_final", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/baud_ctrl.md
# baud_ctrl

Runtime-programmable baud tick controller for the UART. Owns the mod-M divisor counter, arbitrates divisor updates so that a new rate only takes effect on a tick boundary, and lets the RX path realign the tick phase on a start-bit edge. Drives the oversample tick consumed by RX and the 1x bit tick consumed by TX.

## Interface
- `N`, 16: divisor counter width.
- `DEFAULT_DIV`, 27: divisor loaded at reset (50 MHz / (16 × 115200)). Must be ≥ 2 and < 2^N.
- `OVS`, 16: oversample ticks per bit; power of two ≥ 2.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `en` in 1: run the generator.
- `resync` in 1: one-cycle pulse that restarts tick phase.
- `cfg_valid` in 1: divisor write request.
- `cfg_div` in N: requested divisor.
- `cfg_ready` out 1: controller can accept a divisor.
- `cfg_err` out 1: one-cycle pulse when an accepted divisor is invalid.
- `div_q` out N: divisor currently in effect.
- `tick` out 1: oversample tick, one cycle wide.
- `bit_tick` out 1: every OVS-th tick.
- `q` out N: divisor counter value.

## Operation
- Reset, all outputs: state IDLE, `q`=0, `div_q`=DEFAULT_DIV, staged divisor cleared, `ovs_cnt`=0, `tick`=0, `bit_tick`=0, `cfg_ready`=1, `cfg_err`=0.
- States: IDLE (`en`=0), RUN, PEND (a divisor is staged while running).
- IDLE→RUN when `en`=1. RUN/PEND→IDLE when `en`=0. RUN→PEND on a valid transfer. PEND→RUN when the staged divisor is applied.
- Counter: `q` is held at 0 in IDLE. In RUN/PEND it counts 0..`div_q`-1 and wraps to 0.
- `tick` is combinational: `tick` = (state≠IDLE) && `q`==`div_q`-1 && !`resync`.
- `ovs_cnt` increments on each `tick` and wraps at OVS-1. `bit_tick` = `tick` && `ovs_cnt`==OVS-1.
- Handshake: a transfer occurs when `cfg_valid` && `cfg_ready`. `cfg_ready`=1 in IDLE and RUN, 0 in PEND. `cfg_valid` may be held; there is no timeout.
- Divisor < 2: the transfer completes, `cfg_err` pulses the next cycle, `div_q` is unchanged, and there is no state change.
- Valid transfer in IDLE: `div_q` takes the new value on the next edge.
- Valid transfer in RUN: the value is staged and the state goes to PEND. The staged value is applied on the edge that ends a `tick` cycle. On that edge `q`←0 and `ovs_cnt`←0. The `tick` in that cycle, and its `bit_tick` if any, is still emitted at the old rate.
- `resync` in RUN/PEND: next edge `q`←0 and `ovs_cnt`←0; `tick` is suppressed in the `resync` cycle. In PEND, the staged divisor is applied on the same edge. `resync` is ignored in IDLE.
- Priority: `reset` > `en`=0 > `resync` > tick-boundary apply > counting.
- `en`=0 in PEND: the staged divisor is applied on entry to IDLE.
- Simultaneous `en`=0 and a valid transfer: the transfer completes and the value is applied on entry to IDLE.

## Timing
- `en` rises at edge E: the first RUN cycle has `q`=0. The first `tick` is `div_q` cycles after E, then every `div_q` cycles.
- `bit_tick` period is OVS × `div_q` cycles.
- Divisor-change latency: at most the old `div_q` cycles after the transfer. The first new-rate tick arrives `div_q_new` cycles after the apply edge.
- `cfg_err` comes 1 cycle after the transfer.
- `tick` and `bit_tick` have zero-cycle combinational decode from registers.

## Configuration
- `BAUD_CTRL_BIT_TICK_EN` defined: `ovs_cnt` and `bit_tick` are implemented as above.
- `BAUD_CTRL_BIT_TICK_EN` undefined: `ovs_cnt` is removed and `bit_tick` is tied to 0. All other behaviour, including `resync` and apply, is unchanged.

## Structure
- Package `baud_pkg` holds:
  - the state enum (IDLE, RUN, PEND);
  - `MIN_DIV`=2;
  - the default OVS and DEFAULT_DIV constants.
- Sub-module `baud_div_cnt`: a loadable mod-`div_q` counter with synchronous clear, outputting `q` and its wrap flag.
- The FSM, handshake and `ovs_cnt` live in `baud_ctrl`.

## Test plan
- Reset then `en`=1, DEFAULT_DIV=27, OVS=16 → first `tick` 27 cycles after the `en` edge, then every 27 cycles. `bit_tick` every 432 cycles. `q` is 0 throughout reset.
- In IDLE, write `cfg_div`=10 → `cfg_ready`=1, `div_q`=10 next cycle. Then `en`=1 → `tick` every 10 cycles.
- Running at 27, write 5 mid-period (at `q`=8) → `cfg_ready` drops. The `tick` at `q`=26 is still emitted, then ticks follow every 5 cycles with `ovs_cnt` restarted. `cfg_ready` returns to 1 after the apply edge.
- Write `cfg_div`=1 and then 0 → each transfer completes, `cfg_err` pulses once 1 cycle later, and `div_q` stays unchanged.
- `resync` at `q`=20 with `div_q`=27 → no `tick` that cycle, next `tick` 27 cycles after the `resync` edge. `resync` while PEND → the new divisor is applied on that edge.
- `en`=0 while PEND with a staged value of 12 → IDLE next cycle, `div_q`=12, `q`=0, no ticks. `reset` mid-run → all outputs return to reset values on the next edge.
